// File: rtl/mux_add_decoder_pkg.sv
// Shared types and default sizing for the stochastic-to-binary decoder.
package sc_dec_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned LOGWIN_DEF  = 8;
   localparam int unsigned LOGINUM_DEF = 3;
   localparam int unsigned WIN_LEN     = 1 << LOGWIN_DEF;
   localparam int unsigned CNT_W       = LOGWIN_DEF + 1;

endpackage

// File: rtl/mux_add_decoder_window_counter.sv
// Window position and ones counter; strobes on the last valid bit of a window.
module sc_window_counter #(
   parameter int unsigned LOGWIN = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_clr,
   input  logic            i_en,
   input  logic            i_bit,
   output logic            o_last,
   output logic [LOGWIN:0] o_next_count
);

   logic [LOGWIN-1:0] r_win_cnt;
   logic [LOGWIN:0]   r_ones_cnt;

   // ones_cnt is one bit wider than win_cnt so an all-ones window reaches 2^LOGWIN
   assign o_last       = i_en && (r_win_cnt == '1);
   assign o_next_count = r_ones_cnt + {{LOGWIN{1'b0}}, i_bit};

   // Counters clear on an explicit clear or when a window completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win_cnt  <= '0;
         r_ones_cnt <= '0;
      end else if (i_clr || o_last) begin
         r_win_cnt  <= '0;
         r_ones_cnt <= '0;
      end else if (i_en) begin
         r_win_cnt  <= r_win_cnt + 1'b1;
         r_ones_cnt <= o_next_count;
      end
   end

endmodule

// File: rtl/mux_add_decoder.sv
// Converts the mux-adder stochastic bit stream back to binary over a fixed window.
module mux_add_decoder
   import sc_dec_pkg::*;
#(
   parameter int unsigned LOGWIN     = LOGWIN_DEF,
   parameter int unsigned LOGINUM    = LOGINUM_DEF,
   parameter int unsigned CONTINUOUS = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        in_valid,
   input  logic                        in,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [LOGWIN:0]             out_count,
   output logic [LOGWIN+LOGINUM:0]     out_sum,
   output logic                        busy,
   output logic                        overrun
);

   localparam int unsigned SUM_W = LOGWIN + LOGINUM + 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_en;
   logic              w_last;
   logic [LOGWIN:0]   w_next_count;
   logic              r_out_valid;
   logic [LOGWIN:0]   r_out_count;
   logic [SUM_W-1:0]  r_out_sum;
   logic              r_overrun;

   // start takes priority, so a window completing in a start cycle is discarded
   assign w_en = in_valid && (r_state == ACCUM) && !start;

   sc_window_counter #(
      .LOGWIN (LOGWIN)
   ) u_win (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_clr        (start),
      .i_en         (w_en),
      .i_bit        (in),
      .o_last       (w_last),
      .o_next_count (w_next_count)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: start from anywhere, one-shot mode parks in DONE
   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = ACCUM;
      end else begin
         case (r_state)
            ACCUM:   if (w_last && (CONTINUOUS == 0)) w_state_nxt = DONE;
            IDLE:    w_state_nxt = IDLE;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Result registers and valid/ready handshake; a new result overwrites a pending one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_count <= '0;
         r_out_sum   <= '0;
      end else if (w_last) begin
         r_out_valid <= 1'b1;
         r_out_count <= w_next_count;
         r_out_sum   <= SUM_W'(w_next_count) << LOGINUM;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Sticky overrun flag, cleared by start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (start) begin
         r_overrun <= 1'b0;
      end else if (w_last && r_out_valid && !out_ready) begin
         r_overrun <= 1'b1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_count = r_out_count;
   assign out_sum   = r_out_sum;
   assign overrun   = r_overrun;
   assign busy      = (r_state == ACCUM);

endmodule

// File: doc/mux_add_decoder.md
Name: mux_add_decoder

Overview:
- Receiving end of the mux-based scaled-add path: converts the 1-bit stochastic output stream of the 8-input mux adder back to binary.
- Counts ones over a fixed window of 2^LOGWIN valid cycles, which matches the 8-bit Sobol sequence period.
- Reports the raw count and the de-scaled sum (count × INUM, which undoes the adder's 1/INUM scaling) through a valid/ready output handshake.
- Sits downstream of the mux-adder/RNG wrapper, feeding software-visible registers or the next binary stage.

Parameters:
- LOGWIN, 8: log2 of the window length in valid input bits; window = 256.
- LOGINUM, 3: log2 of the mux-adder input count; de-scale shift = 3.
- CONTINUOUS, 1: 1 = back-to-back windows after the first start; 0 = one window per start.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  pulse; clears the counters and begins a window
- in_valid  in  1  qualifies `in` this cycle
- in  in  1  stochastic bit from the mux adder
- out_ready  in  1  consumer accepts the result
- out_valid  out  1  result held stable while high
- out_count  out  LOGWIN+1  ones counted in the window, 0..2^LOGWIN
- out_sum  out  LOGWIN+LOGINUM+1  out_count << LOGINUM
- busy  out  1  high in ACCUM
- overrun  out  1  sticky: a result was overwritten before it was accepted

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters=0.
  - out_valid=0, out_count=0, out_sum=0, busy=0, overrun=0.
- States:
  - IDLE: wait for start.
  - ACCUM: counting.
  - DONE: one-shot mode only; idle with the result pending or delivered.
- start, any state:
  - Next state=ACCUM; ones_cnt=0; win_cnt=0; overrun cleared.
  - The `in` bit sampled in the start cycle is NOT counted.
  - out_valid and the output registers are untouched, so a pending result survives a restart.
- ACCUM:
  - Each cycle with in_valid=1: ones_cnt += in; win_cnt += 1.
  - in_valid=0: hold both counters.
- Window end (in_valid=1 and win_cnt == 2^LOGWIN-1):
  - Next cycle: out_count = ones_cnt + in (the last bit is included); out_sum = that value << LOGINUM; out_valid=1.
  - Result latency is 1 cycle after the last bit.
  - Counters clear in the same edge.
  - CONTINUOUS=1: stay in ACCUM, so the next valid bit is bit 0 of the new window.
  - CONTINUOUS=0: go to DONE with busy=0.
- Output handshake:
  - Transfer occurs on a cycle with out_valid && out_ready; out_valid falls the next cycle.
  - Outputs must not change while out_valid=1 and not accepted, except by overwrite.
- Overwrite: a new result arrives while out_valid=1 with no transfer in that cycle.
  - The new result replaces the old one; out_valid stays 1; overrun=1 (sticky).
  - If the transfer and the new result land in the same cycle, there is no overrun; out_valid stays 1 with the new data.
- Widths and ranges:
  - ones_cnt is LOGWIN+1 bits, because the all-ones window equals 2^LOGWIN and must not wrap.
  - win_cnt is LOGWIN bits and wraps naturally.
- start and window end in the same cycle: start wins. The counters clear and the completing window is discarded; no result is produced.
- Reset mid-window: everything returns to reset values; the partial window is lost.
- DONE: waits for start; the handshake still operates.

Decomposition:
- Package sc_dec_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - localparams WIN_LEN = 1<<LOGWIN and CNT_W = LOGWIN+1.
- Sub-module sc_window_counter:
  - Contains win_cnt and ones_cnt with clear/enable.
  - Emits a last-bit strobe and the next count.
- The top level holds the FSM, the output registers and the handshake.

Test Plan:
- All-ones: start, 256 bits of in=1, in_valid=1, out_ready=1 → one cycle after the last bit: out_valid=1, out_count=256, out_sum=2048; overrun=0.
- Alternating 1010…, with in_valid deasserted every 4th cycle → out_count=128 after exactly 256 valid bits; stall cycles do not count.
- Back-to-back, CONTINUOUS=1, out_ready=0: window A=64 ones, then window B=32 ones → after B: out_count=32, overrun=1; raise out_ready → out_valid drops the next cycle.
- One-shot, CONTINUOUS=0: after the window, state=DONE and busy=0; further in_valid bits do not change the outputs; a new start resumes counting.
- start asserted on the last-bit cycle of the window → no out_valid; the next 256 bits produce the result.
- rst_n pulled low at bit 100 → all outputs 0 immediately (async); after release and start, a full window of all zeros gives out_count=0, out_sum=0.
